otter_mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory bus between the pipelined OTTER's instruction-fetch requester and its MEM-stage data requester.
- Serialises the two request streams and issues back-pressure stalls to both stages.
- Discards fetch responses that were cancelled by a taken branch.
- Includes a watchdog so that a bus that never acknowledges cannot lock up the pipeline.

---
 rtl/otter_mem_pkg.sv | 39 +++
 rtl/arb_watchdog.sv | 35 +++
 rtl/otter_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER instruction/data memory arbiter.
// Covers the FSM states, access sizes and the latched bus command.
package otter_mem_pkg;

  localparam int MAX_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic                  we;
    logic [MAX_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    mem_size_t             size;
    logic                  sign;
  } bus_cmd_t;

  // Instruction fetches are always unsigned full-word reads.
  function automatic bus_cmd_t fetch_cmd(input logic [MAX_ADDR_W-1:0] addr);
    bus_cmd_t c;
    c.we    = 1'b0;
    c.addr  = addr;
    c.wdata = '0;
    c.size  = WORD;
    c.sign  = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter that flags a bus transaction which never acknowledges.
// A TIMEOUT_CYCLES of 0 removes the counter and never expires.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // Fires in the busy cycle whose edge brings the count to TIMEOUT_CYCLES.
      assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/otter_mem_arbiter.sv
// Serialises OTTER fetch and MEM-stage data requests onto one variable-latency
// bus, with data priority, flush-cancelled fetches and a hang watchdog.
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_sign,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [1:0]        m_size,
  output logic              m_sign,
  input  logic              m_ack,
  input  logic [31:0]       m_rdata,
  output logic              err
);

  arb_state_t  state;
  bus_cmd_t    cmd_q;
  logic        m_req_q;
  logic        drop_q;
  logic        if_vld_q;
  logic        d_vld_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        err_q;
  logic        busy;
  logic        wd_expired;
  logic [31:0] resp_word;

  assign busy = (state == DBUSY) || (state == IBUSY);

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .clear  (!busy),
    .enable (busy),
    .expired(wd_expired)
  );

  // Stores and timed-out accesses return zero rather than stale bus data.
  assign resp_word = (m_ack && !cmd_q.we) ? m_rdata : 32'h0;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cmd_q      <= '0;
      m_req_q    <= 1'b0;
      drop_q     <= 1'b0;
      if_vld_q   <= 1'b0;
      d_vld_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            cmd_q.we    <= d_we;
            cmd_q.addr  <= MAX_ADDR_W'(d_addr);
            cmd_q.wdata <= d_wdata;
            cmd_q.size  <= mem_size_t'(d_size);
            cmd_q.sign  <= d_sign;
            m_req_q     <= 1'b1;
            state       <= DBUSY;
          end else if (if_req && !if_flush) begin
            cmd_q   <= fetch_cmd(MAX_ADDR_W'(if_addr));
            m_req_q <= 1'b1;
            drop_q  <= 1'b0;
            state   <= IBUSY;
          end
        end

        DBUSY, IBUSY: begin
          if (state == IBUSY && if_flush) begin
            drop_q <= 1'b1;
          end
          // An acknowledge in the expiry cycle still completes normally.
          if (m_ack || wd_expired) begin
            m_req_q <= 1'b0;
            state   <= RESP;
            if (!m_ack) begin
              err_q <= 1'b1;
            end
            if (state == DBUSY) begin
              d_vld_q   <= 1'b1;
              d_rdata_q <= resp_word;
            end else begin
              if_vld_q   <= !(drop_q || if_flush);
              if_rdata_q <= resp_word;
            end
          end
        end

        RESP: begin
          d_vld_q  <= 1'b0;
          if_vld_q <= 1'b0;
          drop_q   <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign if_valid = if_vld_q && !if_flush;
  assign if_rdata = if_rdata_q;
  assign if_stall = if_req && !if_valid;
  assign d_valid  = d_vld_q;
  assign d_rdata  = d_rdata_q;
  assign d_stall  = d_req && !d_valid;
  assign m_req    = m_req_q;
  assign m_we     = cmd_q.we;
  assign m_addr   = cmd_q.addr[ADDR_W-1:0];
  assign m_wdata  = cmd_q.wdata;
  assign m_size   = cmd_q.size;
  assign m_sign   = cmd_q.sign;
  assign err      = err_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: a transaction-level model checks every
// cycle while directed scenarios pin latencies and data with literal values.
module tb_otter_mem_arbiter;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic        if_valid, if_stall;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_sign;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_valid, d_stall;
  logic [31:0] d_rdata;
  logic        m_req, m_we, m_sign;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  logic        m_ack   = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        err;

  always #5 CLK = ~CLK;

  otter_mem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_sign(d_sign),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size(m_size), .m_sign(m_sign),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus responder: acks ack_delay cycles into m_req (negative = never).
  int          ack_delay;
  logic [31:0] resp_data;
  logic        stray_tog;
  logic        stray_seen = 1'b0;
  int          bcnt = 0;

  always @(posedge CLK) begin
    #2;
    m_ack = 1'b0;
    if (stray_tog != stray_seen) begin
      stray_seen = stray_tog;
      m_ack      = 1'b1;
      m_rdata    = 32'h5555_AAAA;
    end else if (RESET_N && m_req && ack_delay >= 0) begin
      if (bcnt == ack_delay) begin
        m_ack   = 1'b1;
        m_rdata = resp_data;
      end
      bcnt++;
    end
    if (!m_req) bcnt = 0;
  end

  // Transaction-level reference: one access at a time, data first,
  // response one cycle after completion, then one free cycle for acceptance.
  bit          in_txn = 0, exp_issue = 0, resp_due = 0, exp_err = 0;
  bit          flushed = 0, rst_chk = 0, txn_data = 0;
  bit          busy_now, resp_now;
  int          busy_cnt = 0;
  logic        e_we, e_sign;
  logic [31:0] e_addr, e_wdata, exp_rdata;
  logic [1:0]  e_size;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      in_txn = 0; exp_issue = 0; resp_due = 0; exp_err = 0; flushed = 0;
      rst_chk = 1;
    end else begin
      if (rst_chk) begin
        chk1("rst_m_req", m_req, 1'b0);
        chk1("rst_m_we", m_we, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_m_size", {30'b0, m_size}, 32'h0);
        chk1("rst_m_sign", m_sign, 1'b0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_d_valid", d_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        rst_chk = 0;
      end
      chk1("if_stall", if_stall, if_req && !if_valid);
      chk1("d_stall", d_stall, d_req && !d_valid);
      chk1("err", err, exp_err);

      busy_now = exp_issue || in_txn;
      resp_now = resp_due;

      if (resp_due) begin
        if (txn_data) begin
          chk1("d_valid", d_valid, 1'b1);
          chk("d_rdata", d_rdata, exp_rdata);
          chk1("if_valid_during_d_resp", if_valid, 1'b0);
        end else begin
          chk1("if_valid", if_valid, !flushed && !if_flush);
          if (!flushed && !if_flush) chk("if_rdata", if_rdata, exp_rdata);
          chk1("d_valid_during_if_resp", d_valid, 1'b0);
        end
        resp_due = 0;
        flushed  = 0;
      end else begin
        chk1("if_valid_no_resp", if_valid, 1'b0);
        chk1("d_valid_no_resp", d_valid, 1'b0);
      end

      if (exp_issue) begin
        in_txn = 1; busy_cnt = 0; exp_issue = 0;
      end

      if (in_txn) begin
        chk1("m_req", m_req, 1'b1);
        chk1("m_we", m_we, e_we);
        chk("m_addr", m_addr, e_addr);
        chk("m_size", {30'b0, m_size}, {30'b0, e_size});
        if (txn_data) begin
          chk("m_wdata", m_wdata, e_wdata);
          chk1("m_sign", m_sign, e_sign);
        end
        if (!txn_data && if_flush) flushed = 1;
        busy_cnt++;
        if (m_ack) begin
          resp_due  = 1; in_txn = 0;
          exp_rdata = (txn_data && e_we) ? 32'h0 : m_rdata;
        end else if (busy_cnt == TO) begin
          resp_due  = 1; in_txn = 0;
          exp_rdata = 32'h0;
          exp_err   = 1;
        end
      end else begin
        chk1("m_req_idle", m_req, 1'b0);
      end

      if (!busy_now && !resp_now) begin
        if (d_req) begin
          exp_issue = 1; txn_data = 1;
          e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_size = d_size; e_sign = d_sign;
        end else if (if_req && !if_flush) begin
          exp_issue = 1; txn_data = 0;
          e_we = 1'b0; e_addr = if_addr; e_size = 2'b10;
        end
      end
    end
  end

  // Requesters must hold their command while stalled.
  logic        p_dstall = 1'b0, p_istall = 1'b0;
  logic [67:0] p_dcmd;
  logic [31:0] p_iaddr;

  always @(negedge CLK) begin
    if (RESET_N && p_dstall)
      assert (d_req && {d_we, d_addr, d_wdata, d_size, d_sign} == p_dcmd)
        else $error("protocol: data command changed while stalled");
    if (RESET_N && p_istall && !if_flush)
      assert (if_req && if_addr == p_iaddr)
        else $error("protocol: fetch command changed while stalled");
    p_dstall = RESET_N && d_stall;
    p_dcmd   = {d_we, d_addr, d_wdata, d_size, d_sign};
    p_istall = RESET_N && if_stall && !if_flush;
    p_iaddr  = if_addr;
  end

  logic        f_we;
  logic [31:0] f_addr, f_wdata;
  logic [1:0]  f_size;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_pulse(input bit is_data, input int budget, output int lat,
                            output logic [31:0] rd, output int mc, output logic st);
    lat = -1; rd = '0; mc = 0; st = 1'b1;
    f_we = 1'b1; f_addr = '1; f_wdata = '1; f_size = 2'b11;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (m_req) begin
        if (mc == 0) begin
          f_we = m_we; f_addr = m_addr; f_wdata = m_wdata; f_size = m_size;
        end
        mc++;
      end
      if (is_data ? d_valid : if_valid) begin
        lat = i;
        rd  = is_data ? d_rdata : if_rdata;
        st  = is_data ? d_stall : if_stall;
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  int          lat, mc;
  logic [31:0] rd;
  logic        st;

  initial begin
    RESET_N = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_size = 2'b00; d_sign = 1'b0;
    ack_delay = -1; resp_data = '0; stray_tog = 1'b0;
    tick(2);
    chk1("init_m_req", m_req, 1'b0);
    chk1("init_err", err, 1'b0);
    RESET_N = 1'b1;

    // Lone fetch, ack two cycles into m_req.
    ack_delay = 2; resp_data = 32'h0000_0013; if_req = 1'b1; if_addr = 32'h100;
    wait_pulse(1'b0, 20, lat, rd, mc, st);
    chk("fetch_latency", lat, 32'd4);
    chk("fetch_rdata", rd, 32'h13);
    chk("fetch_m_addr", f_addr, 32'h100);
    chk1("fetch_m_we", f_we, 1'b0);
    chk1("fetch_stall_at_valid", st, 1'b0);
    if_req = 1'b0;

    // Contention: data served first, fetch accepted right after RESP.
    ack_delay = 0; resp_data = 32'h8765_4321;
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000; d_size = 2'b10; d_sign = 1'b0;
    wait_pulse(1'b1, 20, lat, rd, mc, st);
    chk("cont_d_latency", lat, 32'd2);
    chk("cont_d_rdata", rd, 32'h8765_4321);
    chk("cont_d_m_addr", f_addr, 32'h6000);
    d_req = 1'b0; resp_data = 32'h0000_0093;
    wait_pulse(1'b0, 20, lat, rd, mc, st);
    chk("cont_if_latency", lat, 32'd2);
    chk("cont_if_rdata", rd, 32'h93);
    chk("cont_if_m_addr", f_addr, 32'h400);
    if_req = 1'b0;

    // Watchdog: never acknowledged load.
    ack_delay = -1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000; d_size = 2'b10;
    wait_pulse(1'b1, 20, lat, rd, mc, st);
    chk("timeout_latency", lat, 32'd5);
    chk("timeout_m_req_cycles", mc, 32'd4);
    chk("timeout_d_rdata", rd, 32'h0);
    d_req = 1'b0;
    tick(3);
    chk1("timeout_err_sticky", err, 1'b1);
    RESET_N = 1'b0;
    tick(1);
    chk1("err_cleared_by_reset", err, 1'b0);
    RESET_N = 1'b1;

    // Flush while the fetch is in flight.
    ack_delay = 3; resp_data = 32'hDEAD_BEEF; if_req = 1'b1; if_addr = 32'h200;
    tick(2);
    if_flush = 1'b1; if_req = 1'b0;
    tick(1);
    if_flush = 1'b0;
    wait_pulse(1'b0, 8, lat, rd, mc, st);
    chk("flush_no_valid", lat, 32'hFFFF_FFFF);
    ack_delay = 1; resp_data = 32'h0010_0093; if_req = 1'b1; if_addr = 32'h300;
    wait_pulse(1'b0, 20, lat, rd, mc, st);
    chk("after_flush_latency", lat, 32'd3);
    chk("after_flush_rdata", rd, 32'h0010_0093);
    chk("after_flush_m_addr", f_addr, 32'h300);
    if_req = 1'b0;

    // Byte store returns zero read data.
    ack_delay = 1; resp_data = 32'hFFFF_FFFF;
    d_req = 1'b1; d_we = 1'b1; d_wdata = 32'hA5; d_size = 2'b00; d_addr = 32'h1100_0000;
    wait_pulse(1'b1, 20, lat, rd, mc, st);
    chk("store_latency", lat, 32'd3);
    chk("store_d_rdata", rd, 32'h0);
    chk("store_m_wdata", f_wdata, 32'hA5);
    chk("store_m_size", {30'b0, f_size}, 32'h0);
    chk1("store_m_we", f_we, 1'b1);
    d_req = 1'b0; d_we = 1'b0;

    // Signed half load, leaving non-zero read data before the next reset.
    resp_data = 32'h0000_1234;
    d_req = 1'b1; d_addr = 32'h9004; d_size = 2'b01; d_sign = 1'b1;
    wait_pulse(1'b1, 20, lat, rd, mc, st);
    chk("load_rdata", rd, 32'h1234);
    d_req = 1'b0; d_sign = 1'b0;

    // Reset in DBUSY, then a stray acknowledge.
    ack_delay = -1; d_req = 1'b1; d_addr = 32'h9000; d_size = 2'b10;
    tick(2);
    RESET_N = 1'b0; d_req = 1'b0;
    tick(1);
    RESET_N = 1'b1; stray_tog = ~stray_tog;
    wait_pulse(1'b1, 6, lat, rd, mc, st);
    chk("stray_ack_no_valid", lat, 32'hFFFF_FFFF);
    chk("stray_ack_no_m_req", mc, 32'd0);
    chk("stray_ack_d_rdata", d_rdata, 32'h0);
    ack_delay = 1; resp_data = 32'h0000_0033; if_req = 1'b1; if_addr = 32'h500;
    wait_pulse(1'b0, 20, lat, rd, mc, st);
    chk("post_reset_latency", lat, 32'd3);
    chk("post_reset_rdata", rd, 32'h33);
    if_req = 1'b0;

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, limit 100000", $time);
    $fatal(1, "bench time limit");
  end

endmodule
